ovi_vpu_frontend: RTL and testbench
===================================

# ovi_vpu_frontend

VPU-side endpoint of the OVI issue/completion protocol. Accepts instructions from the issue bus into a credit-backed queue and returns one issue credit per entry drained. Dispatches entries one at a time to the vector execution unit and reports each result on the completed bus. Sits between the OVI link and the vector execution unit.

## Interface

- QUEUE_DEPTH, default 4: issue queue entries; equals the core-side initial credit count. Must be ≥1.
- CLK  input  1  clock, all logic on rising edge
- RSTN  input  1  synchronous reset, active-low
- VPU_ISSUE  input  vpu_issue_bus  instr, scalar_opnd, sb_id, vcsr, valid; one instruction per cycle while valid=1
- ISSUE_CREDIT  output  1  one-cycle pulse per queue entry freed
- VPU_COMPLETED  output  vpu_completed_bus  dest_reg (64), valid; one-cycle valid per completed instruction
- EXEC_ISSUE  output  vpu_issue_bus  queue head presented to execution unit; valid = request
- EXEC_READY  input  1  execution unit accepts EXEC_ISSUE this cycle
- EXEC_DONE  input  1  execution unit finished the accepted instruction
- EXEC_RESULT  input  64  scalar result, sampled when EXEC_DONE=1
- OVERFLOW  output  1  sticky: issue arrived with queue full

## Operation

- Queue: circular FIFO, QUEUE_DEPTH entries of vpu_issue_bus minus valid. Write/read pointers wrap modulo QUEUE_DEPTH; occupancy counter width $clog2(QUEUE_DEPTH+1).
- Push: VPU_ISSUE.valid=1 and count<QUEUE_DEPTH → store entry at write pointer. If count==QUEUE_DEPTH, entry dropped, OVERFLOW set until reset, even with a same-cycle pop.
- Simultaneous push and pop (count<QUEUE_DEPTH): both happen, count unchanged.
- FSM states IDLE, BUSY, RESP:
  - IDLE: EXEC_ISSUE.valid = (count>0), fields = queue head. If EXEC_READY and count>0 → pop, go BUSY.
  - BUSY: EXEC_ISSUE.valid=0. On EXEC_DONE capture EXEC_RESULT → go RESP.
  - RESP: VPU_COMPLETED.valid=1, dest_reg = captured result, for exactly one cycle → IDLE.
- EXEC_DONE outside BUSY ignored. EXEC_READY with EXEC_ISSUE.valid=0 ignored.
- Credit: each pop registers ISSUE_CREDIT=1 for the following cycle only. At most one pop per cycle, so no credit coalescing.
- Reset (RSTN=0 at a rising edge): count=0, pointers=0, state IDLE, ISSUE_CREDIT=0, VPU_COMPLETED.valid=0, dest_reg=0, OVERFLOW=0, EXEC_ISSUE.valid=0. Applies mid-operation: in-flight instruction abandoned, no completion or credit emitted for it or for queued entries.
- Reset itself issues no credits. The core side restores its QUEUE_DEPTH credits on its own reset.

## Timing

- Issue at edge t → entry in queue after t; EXEC_ISSUE.valid earliest in cycle t+1.
- Pop at edge p (IDLE, EXEC_READY=1) → ISSUE_CREDIT high in cycle p+1; state BUSY in cycle p+1.
- EXEC_DONE sampled at edge d → VPU_COMPLETED.valid high in cycle d+1 only. Next EXEC_ISSUE.valid earliest in cycle d+2.
- Minimum issue-to-completion: 3 cycles after issue edge with EXEC_READY and EXEC_DONE asserted at first opportunity.
- All outputs registered except EXEC_ISSUE, which is combinational from FIFO head and state.

## Structure

- vpu_issue_bus, vpu_completed_bus, v_csr, OVI_SBID_WIDTH and OVI_VSTART_WIDTH live in the shared OVI definitions package/header, not redeclared here.
- Sub-module ovi_issue_fifo: parameterised FIFO with push, pop, head, count, full and empty.
- The FSM, credit pulse, completion register and OVERFLOW sit in the top.

## Test plan

- Reset then single issue instr=0x0000_0057, EXEC_READY=1, EXEC_DONE two cycles after accept with result 0xDEAD_BEEF → one ISSUE_CREDIT pulse; VPU_COMPLETED.valid one cycle with dest_reg=0xDEAD_BEEF.
- Four back-to-back issues with EXEC_READY=0 → count=4, no credits. Then raise READY and complete each → credits and completions in issue order, four of each.
- Fifth issue while count=4 → entry dropped, OVERFLOW=1 and stays 1; the four queued entries complete unchanged.
- Push and pop in the same cycle at count=2 → count stays 2; pointer wrap exercised over 10 instructions with no loss.
- EXEC_DONE pulsed in IDLE → no VPU_COMPLETED.valid.
- RSTN low while BUSY with 3 queued → all outputs return to reset values. After release, with no issues, no credit or completion appears for 20 cycles.

Source files
------------

// File: rtl/ovi_vpu_frontend_pkg.sv
// Shared OVI definitions: issue/completion bus layouts, CSR snapshot and
// the frontend's internal queue-entry and state types.
package ovi_vpu_frontend_pkg;

  localparam int OVI_SBID_WIDTH   = 5;
  localparam int OVI_VSTART_WIDTH = 14;
  localparam int OVI_INSTR_WIDTH  = 32;
  localparam int OVI_XLEN         = 64;

  typedef struct packed {
    logic [OVI_VSTART_WIDTH-1:0] vstart;
    logic [1:0]                  vxrm;
    logic [2:0]                  frm;
    logic [OVI_VSTART_WIDTH:0]   vl;
    logic                        vill;
    logic [2:0]                  vsew;
    logic [2:0]                  vlmul;
  } v_csr;

  typedef struct packed {
    logic [OVI_INSTR_WIDTH-1:0] instr;
    logic [OVI_XLEN-1:0]        scalar_opnd;
    logic [OVI_SBID_WIDTH-1:0]  sb_id;
    v_csr                       vcsr;
    logic                       valid;
  } vpu_issue_bus;

  typedef struct packed {
    logic [OVI_XLEN-1:0] dest_reg;
    logic                valid;
  } vpu_completed_bus;

  // Queue storage carries everything on the issue bus except the strobe.
  typedef struct packed {
    logic [OVI_INSTR_WIDTH-1:0] instr;
    logic [OVI_XLEN-1:0]        scalar_opnd;
    logic [OVI_SBID_WIDTH-1:0]  sb_id;
    v_csr                       vcsr;
  } ovi_issue_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } fe_state_e;

  function automatic ovi_issue_entry_t issue_to_entry(input vpu_issue_bus bus);
    ovi_issue_entry_t e;
    e.instr       = bus.instr;
    e.scalar_opnd = bus.scalar_opnd;
    e.sb_id       = bus.sb_id;
    e.vcsr        = bus.vcsr;
    return e;
  endfunction

  function automatic vpu_issue_bus entry_to_issue(input ovi_issue_entry_t e, input logic vld);
    vpu_issue_bus bus;
    bus.instr       = e.instr;
    bus.scalar_opnd = e.scalar_opnd;
    bus.sb_id       = e.sb_id;
    bus.vcsr        = e.vcsr;
    bus.valid       = vld;
    return bus;
  endfunction

endpackage

// File: rtl/ovi_vpu_frontend_fifo.sv
// ovi_issue_fifo: circular issue queue with occupancy count; pushes when full
// and pops when empty are ignored here so callers need not pre-qualify them.
module ovi_issue_fifo
  import ovi_vpu_frontend_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  ovi_issue_entry_t push_data_i,
  input  logic             pop_i,
  output ovi_issue_entry_t head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  ovi_issue_entry_t mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  always_comb begin
    full_o    = (count_q == CNT_W'(DEPTH));
    empty_o   = (count_q == CNT_W'(0));
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ovi_vpu_frontend.sv
// VPU-side OVI endpoint: queues issued instructions, dispatches them one at a
// time to the execution unit, returns credits and reports completions.
module ovi_vpu_frontend
  import ovi_vpu_frontend_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  vpu_issue_bus        VPU_ISSUE,
  output logic                ISSUE_CREDIT,
  output vpu_completed_bus    VPU_COMPLETED,
  output vpu_issue_bus        EXEC_ISSUE,
  input  logic                EXEC_READY,
  input  logic                EXEC_DONE,
  input  logic [OVI_XLEN-1:0] EXEC_RESULT,
  output logic                OVERFLOW
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  fe_state_e           state_q, state_d;
  logic                credit_q, credit_d;
  logic                cmpl_valid_q, cmpl_valid_d;
  logic [OVI_XLEN-1:0] dest_q, dest_d;
  logic                overflow_q, overflow_d;

  logic                push_s;
  logic                pop_s;
  logic                exec_valid_s;
  ovi_issue_entry_t    head_s;
  logic [CNT_W-1:0]    count_s;
  logic                full_s;
  logic                empty_s;

  assign push_s = VPU_ISSUE.valid && (count_s != CNT_W'(QUEUE_DEPTH));

  ovi_issue_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rstn_i      (RSTN),
    .push_i      (push_s),
    .push_data_i (issue_to_entry(VPU_ISSUE)),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .count_o     (count_s),
    .full_o      (full_s),
    .empty_o     (empty_s)
  );

  always_comb begin
    state_d      = state_q;
    pop_s        = 1'b0;
    exec_valid_s = 1'b0;
    cmpl_valid_d = 1'b0;
    dest_d       = dest_q;
    case (state_q)
      ST_IDLE: begin
        exec_valid_s = !empty_s;
        if (EXEC_READY && !empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (EXEC_DONE) begin
          cmpl_valid_d = 1'b1;
          dest_d       = EXEC_RESULT;
          state_d      = ST_RESP;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    credit_d   = pop_s;
    // A drop is flagged on the pre-pop fullness, even if a pop frees a slot.
    overflow_d = overflow_q || (VPU_ISSUE.valid && full_s);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= ST_IDLE;
      credit_q     <= 1'b0;
      cmpl_valid_q <= 1'b0;
      dest_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      cmpl_valid_q <= cmpl_valid_d;
      dest_q       <= dest_d;
      overflow_q   <= overflow_d;
    end
  end

  assign EXEC_ISSUE             = entry_to_issue(head_s, exec_valid_s);
  assign ISSUE_CREDIT           = credit_q;
  assign VPU_COMPLETED.dest_reg = dest_q;
  assign VPU_COMPLETED.valid    = cmpl_valid_q;
  assign OVERFLOW               = overflow_q;

endmodule

// File: tb/tb_ovi_vpu_frontend.sv
// Scoreboard bench for ovi_vpu_frontend with a small execution-unit model.
module tb_ovi_vpu_frontend;
  import ovi_vpu_frontend_pkg::*;

  localparam int DEPTH = 4;

  logic             CLK;
  logic             RSTN;
  vpu_issue_bus     VPU_ISSUE;
  logic             ISSUE_CREDIT;
  vpu_completed_bus VPU_COMPLETED;
  vpu_issue_bus     EXEC_ISSUE;
  logic             EXEC_READY;
  logic             EXEC_DONE;
  logic [63:0]      EXEC_RESULT;
  logic             OVERFLOW;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] scalar;
    logic [4:0]  sb;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   credits_seen = 0;
  int   cmpl_seen = 0;
  int   occ = 0;
  int   done_cnt = 0;
  int   done_lat = 2;
  int   pulse_req = 0;
  int   pulse_ack = 0;
  logic ready_en = 1'b0;
  logic model_on = 1'b0;
  logic inflight = 1'b0;
  logic [63:0] inflight_res = '0;
  logic exp_credit = 1'b0, exp_cmpl = 1'b0, exp_ovf = 1'b0;
  logic [4:0] sb_ctr = 5'd0;

  ovi_vpu_frontend #(.QUEUE_DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RSTN          (RSTN),
    .VPU_ISSUE     (VPU_ISSUE),
    .ISSUE_CREDIT  (ISSUE_CREDIT),
    .VPU_COMPLETED (VPU_COMPLETED),
    .EXEC_ISSUE    (EXEC_ISSUE),
    .EXEC_READY    (EXEC_READY),
    .EXEC_DONE     (EXEC_DONE),
    .EXEC_RESULT   (EXEC_RESULT),
    .OVERFLOW      (OVERFLOW)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Execution-unit model and cycle-level scoreboard, sampled 3 time units after each edge.
  initial begin
    logic exp_vld, full_pre, nxt_credit, nxt_cmpl, nxt_ovf;
    EXEC_READY  = 1'b0;
    EXEC_DONE   = 1'b0;
    EXEC_RESULT = '0;
    wait (model_on);
    forever begin
      @(posedge CLK);
      #3;
      if (ISSUE_CREDIT === 1'b1) credits_seen++;
      if (VPU_COMPLETED.valid === 1'b1) cmpl_seen++;
      exp_vld = (occ > 0) && !inflight && !exp_cmpl;
      check_eq("credit", 64'(ISSUE_CREDIT), 64'(exp_credit));
      check_eq("cmpl_valid", 64'(VPU_COMPLETED.valid), 64'(exp_cmpl));
      check_eq("overflow", 64'(OVERFLOW), 64'(exp_ovf));
      check_eq("exec_valid", 64'(EXEC_ISSUE.valid), 64'(exp_vld));
      if (exp_cmpl && exp_q.size() > 0) begin
        check_eq("cmpl_data", VPU_COMPLETED.dest_reg, exp_q[0].scalar);
        void'(exp_q.pop_front());
      end
      nxt_credit = 1'b0;
      nxt_cmpl   = 1'b0;
      nxt_ovf    = exp_ovf;
      full_pre   = (occ == DEPTH);
      EXEC_DONE  = 1'b0;
      EXEC_READY = ready_en;
      if (!RSTN) begin
        occ      = 0;
        inflight = 1'b0;
        nxt_ovf  = 1'b0;
        exp_q.delete();
      end else begin
        if (exp_vld && ready_en && exp_q.size() > 0) begin
          check_eq("acc_instr", 64'(EXEC_ISSUE.instr), 64'(exp_q[0].instr));
          check_eq("acc_sbid", 64'(EXEC_ISSUE.sb_id), 64'(exp_q[0].sb));
          inflight     = 1'b1;
          done_cnt     = done_lat;
          inflight_res = EXEC_ISSUE.scalar_opnd;
          occ--;
          nxt_credit   = 1'b1;
        end else if (inflight) begin
          done_cnt--;
          if (done_cnt <= 0) begin
            EXEC_DONE   = 1'b1;
            EXEC_RESULT = inflight_res;
            inflight    = 1'b0;
            nxt_cmpl    = 1'b1;
          end
        end else if (pulse_req != pulse_ack) begin
          EXEC_DONE   = 1'b1;
          EXEC_RESULT = 64'h0BAD_0BAD_0BAD_0BAD;
          pulse_ack++;
        end
        if (VPU_ISSUE.valid) begin
          if (full_pre) begin
            nxt_ovf = 1'b1;
          end else begin
            exp_q.push_back('{instr: VPU_ISSUE.instr, scalar: VPU_ISSUE.scalar_opnd, sb: VPU_ISSUE.sb_id});
            occ++;
          end
        end
      end
      exp_credit = nxt_credit;
      exp_cmpl   = nxt_cmpl;
      exp_ovf    = nxt_ovf;
    end
  end

  task automatic drive_issue(input logic [31:0] instr, input logic [63:0] scalar);
    @(posedge CLK);
    #1;
    VPU_ISSUE             = '0;
    VPU_ISSUE.valid       = 1'b1;
    VPU_ISSUE.instr       = instr;
    VPU_ISSUE.scalar_opnd = scalar;
    VPU_ISSUE.sb_id       = sb_ctr;
    VPU_ISSUE.vcsr.vl     = 15'(sb_ctr);
    sb_ctr                = sb_ctr + 5'd1;
  endtask

  task automatic idle_issue();
    @(posedge CLK);
    #1;
    VPU_ISSUE.valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge CLK);
      k++;
    end
    if (k >= 200) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN      = 1'b0;
    VPU_ISSUE = '0;
    repeat (3) @(posedge CLK);
    #1;
    model_on = 1'b1;
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    #1;
    check_eq("rst_credit", 64'(ISSUE_CREDIT), 64'd0);
    check_eq("rst_cmpl", 64'(VPU_COMPLETED.valid), 64'd0);
    check_eq("rst_dest", VPU_COMPLETED.dest_reg, 64'd0);
    check_eq("rst_ovf", 64'(OVERFLOW), 64'd0);
    check_eq("rst_exec_valid", 64'(EXEC_ISSUE.valid), 64'd0);

    // Single instruction, result returned two cycles after accept
    ready_en = 1'b1;
    drive_issue(32'h0000_0057, 64'h0000_0000_DEAD_BEEF);
    idle_issue();
    drain();
    check_eq("t1_credits", 64'(credits_seen), 64'd1);
    check_eq("t1_cmpls", 64'(cmpl_seen), 64'd1);
    check_eq("t1_dest", VPU_COMPLETED.dest_reg, 64'h0000_0000_DEAD_BEEF);

    // Push and pop in the same cycle, then fill to four and overflow
    ready_en = 1'b0;
    drive_issue(32'h1000_0001, 64'hA1);
    drive_issue(32'h1000_0002, 64'hA2);
    drive_issue(32'h1000_0003, 64'hA3);
    ready_en = 1'b1;
    idle_issue();
    ready_en = 1'b0;
    repeat (6) @(posedge CLK);
    check_eq("t2_credits", 64'(credits_seen), 64'd2);
    drive_issue(32'h1000_0004, 64'hA4);
    drive_issue(32'h1000_0005, 64'hA5);
    idle_issue();
    repeat (2) @(posedge CLK);
    check_eq("t3_no_ovf_yet", 64'(OVERFLOW), 64'd0);
    drive_issue(32'h1000_0006, 64'hA6);
    idle_issue();
    repeat (2) @(posedge CLK);
    #2;
    check_eq("t3_ovf", 64'(OVERFLOW), 64'd1);
    check_eq("t3_no_credit", 64'(credits_seen), 64'd2);
    ready_en = 1'b1;
    drain();
    check_eq("t3_credits", 64'(credits_seen), 64'd6);
    check_eq("t3_cmpls", 64'(cmpl_seen), 64'd6);
    check_eq("t3_ovf_sticky", 64'(OVERFLOW), 64'd1);

    // Ten instructions spaced out so the pointers wrap several times
    done_lat = 1;
    for (int i = 0; i < 10; i++) begin
      drive_issue(32'h2000_0000 + 32'(i), {32'h5A5A_0000, 32'(i * 7 + 3)});
      idle_issue();
      @(posedge CLK);
    end
    drain();
    check_eq("wrap_credits", 64'(credits_seen), 64'd16);
    check_eq("wrap_cmpls", 64'(cmpl_seen), 64'd16);

    // EXEC_DONE while idle must be ignored
    repeat (2) @(posedge CLK);
    pulse_req++;
    repeat (4) @(posedge CLK);
    check_eq("idle_done_ignored", 64'(cmpl_seen), 64'd16);

    // Reset while busy with three entries still queued
    ready_en = 1'b0;
    done_lat = 40;
    for (int i = 0; i < 4; i++) drive_issue(32'h3000_0000 + 32'(i), 64'(i + 100));
    idle_issue();
    @(posedge CLK);
    #1;
    ready_en = 1'b1;
    @(posedge CLK);
    #1;
    ready_en = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    ready_en = 1'b1;
    #1;
    check_eq("mid_rst_ovf", 64'(OVERFLOW), 64'd0);
    check_eq("mid_rst_dest", VPU_COMPLETED.dest_reg, 64'd0);
    check_eq("mid_rst_exec_valid", 64'(EXEC_ISSUE.valid), 64'd0);
    repeat (20) @(posedge CLK);
    check_eq("post_rst_credits", 64'(credits_seen), 64'd17);
    check_eq("post_rst_cmpls", 64'(cmpl_seen), 64'd16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
